// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button debounce / strobe logic.
// Holds the channel state encodings, the default cycle counts for a 50 MHz
// clock and small helpers used by key_channel.
package key_pkg;

  // Channel FSM encoding, kept as plain constants so older tools can read it.
  typedef logic [2:0] key_state_t;

  localparam key_state_t IDLE   = 3'd0;
  localparam key_state_t DEB_DN = 3'd1;
  localparam key_state_t HELD   = 3'd2;
  localparam key_state_t REPEAT = 3'd3;
  localparam key_state_t DEB_UP = 3'd4;

  // Default timing at 50 MHz: 10 ms debounce, 500 ms hold, 100 ms repeat.
  localparam int unsigned DEF_DEB_CYCLES    = 500000;
  localparam int unsigned DEF_HOLD_CYCLES   = 25000000;
  localparam int unsigned DEF_REPEAT_CYCLES = 5000000;
  localparam int unsigned DEF_CNT_W         = 25;

  // The key counts as pressed (debounced) in every state after acceptance.
  function automatic logic isHeldState(input key_state_t s);
    return (s == HELD) || (s == REPEAT) || (s == DEB_UP);
  endfunction

  // Largest of the three timing parameters; the counter never goes past it.
  function automatic int unsigned maxCycles(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push-button path -- 2-FF synchronizer, debounce FSM and
// its cycle counter. Produces a combinational raw press/repeat pulse and the
// held level of the state being entered, so the parent can register both in
// the same cycle.
// Optional feature macro: KEY_AUTOREPEAT_EN (adds HELD timeout and REPEAT).
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_pulse,
  output logic o_held
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  =
    CNT_W'(maxCycles(DEB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES) - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]       r_sync;
  key_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  key_state_t w_state_nxt;
  logic       w_act;
  logic       w_cnt_en;
  logic       w_cnt_clr;
  logic       w_pulse;

  // Bring the raw pin into the clock domain; reset parks it at "released".
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
    end
  end

  assign w_act = ~r_sync[1];

  // Next-state decode: a release/press always wins over a pending timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_en    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_pulse     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_act) w_state_nxt = DEB_DN;
      end
      DEB_DN: begin
        if (!w_act) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_pulse     = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      HELD: begin
        if (!w_act) begin
          w_state_nxt = DEB_UP;
`ifdef KEY_AUTOREPEAT_EN
        end else if (r_cnt == HOLD_LAST) begin
          w_state_nxt = REPEAT;
          w_pulse     = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
`endif
        end
      end
`ifdef KEY_AUTOREPEAT_EN
      REPEAT: begin
        if (!w_act) begin
          w_state_nxt = DEB_UP;
        end else if (r_cnt == REP_LAST) begin
          w_pulse   = 1'b1;
          w_cnt_clr = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
`endif
      DEB_UP: begin
        if (w_act) begin
          w_state_nxt = HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset forces IDLE even in the middle of a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cycle counter: cleared on any state change or repeat tick, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((w_state_nxt != r_state) || w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_en && (r_cnt != CNT_SAT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_pulse = w_pulse;
  assign o_held  = isHeldState(w_state_nxt);

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: debounces the increment/decrement buttons and emits
// single-cycle plus/min strobes plus debounced held levels for time_counter.
// While both keys are held, both strobes are suppressed.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat while a key is held).
module key_pulse_gen
  import key_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic key_plus_n,
  input  logic key_min_n,
  output logic plus,
  output logic min,
  output logic plus_held,
  output logic min_held
);

  logic w_plus_pulse;
  logic w_min_pulse;
  logic w_plus_held;
  logic w_min_held;
  logic w_conflict;

  logic r_plus;
  logic r_min;
  logic r_plus_held;
  logic r_min_held;

  key_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_plus (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_plus_n),
    .o_pulse (w_plus_pulse),
    .o_held  (w_plus_held)
  );

  key_channel #(
    .DEB_CYCLES    (DEB_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES),
    .REPEAT_CYCLES (REPEAT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_min (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_key_n (key_min_n),
    .o_pulse (w_min_pulse),
    .o_held  (w_min_held)
  );

  // Uses the held levels being entered, so a pulse coinciding with the
  // second key becoming held is already suppressed.
  assign w_conflict = w_plus_held & w_min_held;

  // Output registers: masked strobes and debounced held levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_plus      <= 1'b0;
      r_min       <= 1'b0;
      r_plus_held <= 1'b0;
      r_min_held  <= 1'b0;
    end else begin
      r_plus      <= w_plus_pulse & ~w_conflict;
      r_min       <= w_min_pulse & ~w_conflict;
      r_plus_held <= w_plus_held;
      r_min_held  <= w_min_held;
    end
  end

  assign plus      = r_plus;
  assign min       = r_min;
  assign plus_held = r_plus_held;
  assign min_held  = r_min_held;

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: scenario tasks plus a randomized run, all compared
// against a run-length model of the debounce / hold / repeat rules.
`timescale 1ns/1ps
module tb_key_pulse_gen;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_plus_n = 1'b1;
  logic key_min_n = 1'b1;
  logic plus, min, plus_held, min_held;

  int checks = 0;
  int failures = 0;
  int edgeNo = 0;

  // Model state: two-sample pin delay, then run-length debounce per key.
  bit mDelay [2][2];
  bit mPressed [2];
  int mAgree [2];
  int mDisagree [2];
  int mTimer [2];
  bit mRepeating [2];
  bit expPlus, expMin, expPlusHeld, expMinHeld;

  key_pulse_gen #(
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_plus_n (key_plus_n),
    .key_min_n  (key_min_n),
    .plus       (plus),
    .min        (min),
    .plus_held  (plus_held),
    .min_held   (min_held)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      mDelay[c][0] = 1'b1;
      mDelay[c][1] = 1'b1;
      mPressed[c] = 1'b0;
      mAgree[c] = 0;
      mDisagree[c] = 0;
      mTimer[c] = 0;
      mRepeating[c] = 1'b0;
    end
    expPlus = 0; expMin = 0; expPlusHeld = 0; expMinHeld = 0;
  endtask

  // A level change is accepted after DEB+1 consecutive agreeing samples;
  // while pressed, HOLD then every REP steady samples give a repeat.
  task automatic modelChannel(input int ch, input bit act, output bit pulse);
    pulse = 1'b0;
    if (!mPressed[ch]) begin
      if (act) begin
        mAgree[ch]++;
        if (mAgree[ch] == DEB + 1) begin
          mPressed[ch] = 1'b1;
          pulse = 1'b1;
          mAgree[ch] = 0;
          mDisagree[ch] = 0;
          mTimer[ch] = 0;
          mRepeating[ch] = 1'b0;
        end
      end else begin
        mAgree[ch] = 0;
      end
    end else if (!act) begin
      mDisagree[ch]++;
      if (mDisagree[ch] == DEB + 1) begin
        mPressed[ch] = 1'b0;
        mDisagree[ch] = 0;
        mAgree[ch] = 0;
      end
    end else if (mDisagree[ch] > 0) begin
      mDisagree[ch] = 0;
      mTimer[ch] = 0;
      mRepeating[ch] = 1'b0;
    end else if (AUTO_REP) begin
      mTimer[ch]++;
      if (mTimer[ch] == (mRepeating[ch] ? REP : HOLD)) begin
        pulse = 1'b1;
        mTimer[ch] = 0;
        mRepeating[ch] = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle 1 ns.
  task automatic step(input bit kp, input bit km, input bit r);
    bit act0, act1, p0, p1, both;
    key_plus_n = kp;
    key_min_n = km;
    rst = r;
    @(posedge clk);
    if (r) begin
      modelReset();
    end else begin
      act0 = !mDelay[0][1];
      act1 = !mDelay[1][1];
      mDelay[0][1] = mDelay[0][0]; mDelay[0][0] = kp;
      mDelay[1][1] = mDelay[1][0]; mDelay[1][0] = km;
      modelChannel(0, act0, p0);
      modelChannel(1, act1, p1);
      both = mPressed[0] & mPressed[1];
      expPlus = p0 & !both;
      expMin = p1 & !both;
      expPlusHeld = mPressed[0];
      expMinHeld = mPressed[1];
    end
    edgeNo++;
    #1;
  endtask

  task automatic idleSteps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++;
    if ({plus, min, plus_held, min_held} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got %b want 0000", {plus, min, plus_held, min_held});
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL reset_idle edge %0d: got %b want %b", edgeNo,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
    end
  endtask

  task automatic test_clean_press();
    int strobes = 0, strobeAt = 0, minSeen = 0;
    bit heldAtStrobe = 0;
    idleSteps(14);
    for (int i = 1; i <= 20; i++) begin
      step((i <= 8) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL clean_press edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (plus) begin strobes++; strobeAt = i; heldAtStrobe = plus_held; end
      if (min || min_held) minSeen++;
    end
    checks++;
    if (strobes != 1 || strobeAt != DEB + 3 || !heldAtStrobe || minSeen != 0) begin
      failures++;
      $display("[TB] FAIL clean_press_timing: got strobes=%0d at=%0d held=%0d minSeen=%0d want 1 at %0d held=1 minSeen=0",
               strobes, strobeAt, heldAtStrobe, minSeen, DEB + 3);
    end
  endtask

  task automatic test_bounce();
    int minActivity = 0;
    bit km;
    idleSteps(14);
    for (int i = 0; i < 32; i++) begin
      km = (i < 20) ? ((i % 4) == 3) : 1'b1;
      step(1'b1, km, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL bounce edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (min || min_held) minActivity++;
    end
    checks++;
    if (minActivity != 0) begin
      failures++;
      $display("[TB] FAIL bounce_quiet: got %0d active cycles want 0", minActivity);
    end
  endtask

  task automatic test_autorepeat();
    int got[$];
    int want[$];
    bit ok;
    if (AUTO_REP) want = '{7, 17, 20, 23, 26, 29};
    else want = '{7};
    idleSteps(14);
    for (int i = 1; i <= 44; i++) begin
      step((i <= 30) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL autorepeat edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (plus && i <= 30) got.push_back(i);
    end
    ok = (got.size() == want.size());
    if (ok) for (int k = 0; k < want.size(); k++) if (got[k] != want[k]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL autorepeat_edges: got %p want %p", got, want);
    end
  endtask

  task automatic test_release_glitch();
    int extra = 0, heldDrops = 0;
    bit kp;
    idleSteps(14);
    for (int i = 1; i <= 32; i++) begin
      kp = (i <= 10) ? 1'b0 : (i <= 12) ? 1'b1 : (i <= 18) ? 1'b0 : 1'b1;
      step(kp, 1'b1, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL release_glitch edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (i >= 8 && i <= 18 && plus) extra++;
      if (i >= 7 && i <= 18 && !plus_held) heldDrops++;
    end
    checks++;
    if (extra != 0 || heldDrops != 0) begin
      failures++;
      $display("[TB] FAIL release_glitch_hold: got extra=%0d drops=%0d want 0 and 0", extra, heldDrops);
    end
  endtask

  task automatic test_conflict();
    int firstPlus = 0, duringBoth = 0, minTotal = 0, resumed = 0;
    bit minWasHeld = 0;
    bit kp, km;
    idleSteps(14);
    for (int i = 1; i <= 72; i++) begin
      kp = (i <= 60) ? 1'b0 : 1'b1;
      km = (i >= 11 && i <= 30) ? 1'b0 : 1'b1;
      step(kp, km, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL conflict edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (plus && i == DEB + 3) firstPlus++;
      if ((plus || min) && plus_held && min_held) duringBoth++;
      if (min) minTotal++;
      if (min_held) minWasHeld = 1;
      else if (minWasHeld && plus) resumed++;
    end
    checks++;
    if (firstPlus != 1 || duringBoth != 0 || minTotal != 0 || !minWasHeld) begin
      failures++;
      $display("[TB] FAIL conflict_mask: got first=%0d both=%0d min=%0d minHeld=%0d want 1 0 0 1",
               firstPlus, duringBoth, minTotal, minWasHeld);
    end
    checks++;
    if ((resumed != 0) != AUTO_REP) begin
      failures++;
      $display("[TB] FAIL conflict_resume: got %0d resumed strobes want nonzero=%0d", resumed, AUTO_REP);
    end
  endtask

  task automatic test_reset_mid_hold();
    int firstAfter = -1;
    idleSteps(14);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({plus, min, plus_held, min_held} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold_outputs: got %b want 0000", {plus, min, plus_held, min_held});
    end
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL reset_mid_hold edge %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
      if (plus && firstAfter < 0) firstAfter = i;
    end
    // The synchronizer restarts from "released", so a full press latency applies.
    checks++;
    if (firstAfter != DEB + 3) begin
      failures++;
      $display("[TB] FAIL reset_mid_hold_latency: got %0d want %0d", firstAfter, DEB + 3);
    end
    idleSteps(14);
  endtask

  task automatic test_random();
    bit kp = 1, km = 1, r;
    int runP = 0, runM = 0;
    for (int i = 0; i < 1500; i++) begin
      if (runP == 0) begin kp = ~kp; runP = $urandom_range(1, 14); end
      if (runM == 0) begin km = ~km; runM = $urandom_range(1, 14); end
      runP--; runM--;
      r = ($urandom_range(0, 299) == 0);
      step(kp, km, r);
      checks++;
      if ({plus, min, plus_held, min_held} !== {expPlus, expMin, expPlusHeld, expMinHeld}) begin
        failures++;
        $display("[TB] FAIL random cycle %0d: got %b want %b", i,
                 {plus, min, plus_held, min_held}, {expPlus, expMin, expPlusHeld, expMinHeld});
      end
    end
  endtask

  initial begin
    modelReset();
    $display("[TB] key_pulse_gen bench, autorepeat=%0d", AUTO_REP);
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_release_glitch();
    test_conflict();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
